// File: rtl/operand_fetch_pipe.sv
// Operand-fetch stage: register-file read, writeback bypass, load-use stall, output slot.
// Optional OF_BYPASS_EN: writeback bypass; otherwise a writeback conflict stalls one cycle.
module operand_fetch_pipe #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 16,
    parameter int PC_W     = 8,
    parameter int CTRL_W   = 8,
    parameter int IMM_W    = 8,
    parameter int CNT_W    = 16,
    localparam int REG_AW  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_dst_sel,
    input  logic              in_rd_we,
    input  logic [IMM_W-1:0]  in_imm,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [IMM_W-1:0]  out_imm,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_rd_we,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              hazard_lu;
    logic              hazard_wb;
    logic              accept;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    assign hazard_lu = ex_valid & ex_is_load &
                       ((in_use_rs1 & (ex_rd == in_rs1)) | (in_use_rs2 & (ex_rd == in_rs2)));

`ifdef OF_BYPASS_EN
    assign hazard_wb = 1'b0;
    assign op1 = (wb_we && wb_addr == in_rs1) ? wb_data : rf_rdata1;
    assign op2 = (wb_we && wb_addr == in_rs2) ? wb_data : rf_rdata2;
`else
    // No forwarding path: wait one cycle until the write has landed in the register file.
    assign hazard_wb = wb_we &
                       ((in_use_rs1 & (wb_addr == in_rs1)) | (in_use_rs2 & (wb_addr == in_rs2)));
    assign op1 = rf_rdata1;
    assign op2 = rf_rdata2;
`endif

    assign in_ready = !hazard_lu && !hazard_wb && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_ctrl  <= '0;
            out_imm   <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            stall_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;

            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_pc    <= in_pc;
                out_ctrl  <= in_ctrl;
                out_imm   <= in_imm;
                out_rd    <= in_dst_sel ? in_rd : in_rs1;
                out_rd_we <= in_rd_we;
                out_op1   <= op1;
                out_op2   <= op2;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_pipe.sv
// Directed bench for operand_fetch_pipe; a second instance with CNT_W=2 checks saturation.
module tb_operand_fetch_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_ready_s;
    logic [7:0]  in_pc, in_ctrl, in_imm;
    logic [3:0]  in_rs1, in_rs2, in_rd, rf_raddr1, rf_raddr2;
    logic        in_use_rs1, in_use_rs2, in_dst_sel, in_rd_we;
    logic [63:0] rf_rdata1, rf_rdata2, wb_data;
    logic        wb_we, ex_valid, ex_is_load, out_ready;
    logic [3:0]  wb_addr, ex_rd;
    logic        out_valid, out_rd_we;
    logic [7:0]  out_pc, out_ctrl, out_imm;
    logic [3:0]  out_rd;
    logic [63:0] out_op1, out_op2;
    logic [15:0] stall_cnt;

    logic [3:0]  raddr1_s, raddr2_s, out_rd_s;
    logic        out_valid_s, out_rd_we_s;
    logic [7:0]  out_pc_s, out_ctrl_s, out_imm_s;
    logic [63:0] out_op1_s, out_op2_s;
    logic [1:0]  stall_cnt_s;

    logic [63:0] rf [16];
    int checks = 0;
    int errors = 0;
    int s;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk = ~clk;

    operand_fetch_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ctrl(in_ctrl), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_rd(in_rd),
        .in_dst_sel(in_dst_sel), .in_rd_we(in_rd_we), .in_imm(in_imm),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ctrl(out_ctrl),
        .out_imm(out_imm), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_op1(out_op1), .out_op2(out_op2), .stall_cnt(stall_cnt)
    );

    operand_fetch_pipe #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_pc(in_pc), .in_ctrl(in_ctrl), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_rd(in_rd),
        .in_dst_sel(in_dst_sel), .in_rd_we(in_rd_we), .in_imm(in_imm),
        .rf_raddr1(raddr1_s), .rf_raddr2(raddr2_s), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_pc(out_pc_s), .out_ctrl(out_ctrl_s),
        .out_imm(out_imm_s), .out_rd(out_rd_s), .out_rd_we(out_rd_we_s),
        .out_op1(out_op1_s), .out_op2(out_op2_s), .stall_cnt(stall_cnt_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 64'(i);
        rf[2] = 64'h22; rf[3] = 64'hAA; rf[5] = 64'hBB; rf[7] = 64'h77;
        rst_n = 0; flush = 0; in_valid = 0; in_pc = 0; in_ctrl = 0; in_imm = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_use_rs1 = 0; in_use_rs2 = 0;
        in_dst_sel = 0; in_rd_we = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; out_ready = 0;
        tick(); tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_op1", out_op1, 64'd0);
        rst_n = 1;

        // Basic accept, 1-cycle latency
        in_valid = 1; in_pc = 8'h10; in_ctrl = 8'h5A; in_imm = 8'h42;
        in_rs1 = 3; in_rs2 = 5; in_use_rs1 = 1; in_use_rs2 = 1;
        in_rd = 9; in_dst_sel = 1; in_rd_we = 1; out_ready = 1;
        #1;
        chk("t1_ready", 64'(in_ready), 64'd1);
        chk("t1_raddr1", 64'(rf_raddr1), 64'd3);
        tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_op1", out_op1, 64'hAA);
        chk("t1_op2", out_op2, 64'hBB);
        chk("t1_pc", 64'(out_pc), 64'h10);
        chk("t1_ctrl", 64'(out_ctrl), 64'h5A);
        chk("t1_imm", 64'(out_imm), 64'h42);
        chk("t1_rd", 64'(out_rd), 64'd9);
        chk("t1_rdwe", 64'(out_rd_we), 64'd1);
        in_valid = 0;
        tick();
        chk("t1_drain", 64'(out_valid), 64'd0);

        // Writeback conflict on rs2
        in_valid = 1; in_pc = 8'h11; wb_we = 1; wb_addr = 5; wb_data = 64'h1234;
        #1;
`ifdef OF_BYPASS_EN
        s = 0;
        chk("t2_ready", 64'(in_ready), 64'd1);
        tick();
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_op2", out_op2, 64'h1234);
        chk("t2_cnt", 64'(stall_cnt), 64'd0);
        wb_we = 0;
`else
        s = 1;
        chk("t2_ready", 64'(in_ready), 64'd0);
        tick();
        chk("t2_stall", 64'(out_valid), 64'd0);
        chk("t2_cnt", 64'(stall_cnt), 64'd1);
        wb_we = 0;
        #1;
        chk("t2_ready2", 64'(in_ready), 64'd1);
        tick();
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_op2", out_op2, 64'hBB);
        chk("t2_pc", 64'(out_pc), 64'h11);
`endif
        in_valid = 0;
        tick();
        chk("t2_drain", 64'(out_valid), 64'd0);

        // Load-use hazard on rs1
        ex_valid = 1; ex_is_load = 1; ex_rd = 3; in_valid = 1; in_pc = 8'h12;
        #1;
        chk("t3_ready", 64'(in_ready), 64'd0);
        in_use_rs1 = 0;
        #1;
        chk("t3_unused", 64'(in_ready), 64'd1);
        in_use_rs1 = 1;
        #1;
        tick(); tick();
        chk("t3_cnt", 64'(stall_cnt), 64'(s + 2));
        chk("t3_cnt_s", 64'(stall_cnt_s), 64'(s + 2));
        chk("t3_noacc", 64'(out_valid), 64'd0);
        ex_valid = 0;
        #1;
        chk("t3_ready2", 64'(in_ready), 64'd1);
        tick();
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_pc", 64'(out_pc), 64'h12);

        // Back-pressure hold, then drain+accept on one edge
        out_ready = 0; in_pc = 8'h13; in_rs1 = 7; in_rs2 = 2; in_rd = 2; in_dst_sel = 0;
        #1;
        chk("t4_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_hold_v", 64'(out_valid), 64'd1);
            chk("t4_hold_pc", 64'(out_pc), 64'h12);
            chk("t4_hold_op1", out_op1, 64'hAA);
        end
        chk("t4_cnt", 64'(stall_cnt), 64'(s + 6));
        chk("t4_sat", 64'(stall_cnt_s), 64'd3);
        out_ready = 1;
        #1;
        chk("t4_ready2", 64'(in_ready), 64'd1);
        tick();
        chk("t4_valid", 64'(out_valid), 64'd1);
        chk("t4_pc", 64'(out_pc), 64'h13);
        chk("t4_rd_rs1", 64'(out_rd), 64'd7);
        chk("t4_op1", out_op1, 64'h77);
        chk("t4_op2", out_op2, 64'h22);

        // Flush drops slot and incoming instruction
        flush = 1; in_pc = 8'h14; in_dst_sel = 1;
        #1;
        chk("t5_ready", 64'(in_ready), 64'd1);
        tick();
        chk("t5_flushed", 64'(out_valid), 64'd0);
        flush = 0; in_valid = 0;
        tick();
        chk("t5_dropped", 64'(out_valid), 64'd0);
        chk("t5_cnt", 64'(stall_cnt), 64'(s + 6));
        in_valid = 1; in_pc = 8'h15;
        tick();
        chk("t5_valid", 64'(out_valid), 64'd1);
        chk("t5_rd", 64'(out_rd), 64'd2);
        chk("t5_pc", 64'(out_pc), 64'h15);
        in_valid = 0;

        // Reset with a valid slot
        out_ready = 0;
        rst_n = 0;
        tick();
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_pc", 64'(out_pc), 64'd0);
        chk("t6_cnt", 64'(stall_cnt), 64'd0);
        chk("t6_cnt_s", 64'(stall_cnt_s), 64'd0);
        rst_n = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
